// File: rtl/card_mem_pkg.sv
// Shared constants for the card store and the arbiter state encoding.
package card_mem_pkg;

  localparam int unsigned ADDR_W       = 10;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BLOCK_STRIDE = 32;
  localparam int unsigned ALLOC_BIT    = 31;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_DRAIN   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  output logic             valid,
  output logic [PTR_W-1:0] index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    // Scan from the farthest offset down so the nearest match wins.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[(int'(pointer) + i) % int'(N)]) begin
        valid = 1'b1;
        index = PTR_W'((int'(pointer) + i) % int'(N));
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port card RAM between list engines,
// with a hold watchdog that revokes long-held grants.
module ram_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = card_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W   = card_mem_pkg::DATA_W,
  parameter int unsigned MAX_HOLD = 1023
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          rel,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic [NUM_REQ*ADDR_W-1:0]   m_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   m_data,
  input  logic [NUM_REQ-1:0]          m_wren,
  output logic [DATA_W-1:0]           rd_data,
  output logic [ADDR_W-1:0]           ram_address,
  output logic [DATA_W-1:0]           ram_data,
  output logic                        ram_wren,
  input  logic [DATA_W-1:0]           ram_q,
  output logic                        busy,
  output logic [2:0]                  owner,
  output logic                        timeout
);

  import card_mem_pkg::*;

  localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_e         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner_idx;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic               owner_rel;
  logic               owner_req;
  logic               wd_hit;

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req     (req),
    .pointer (rr_ptr),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  assign owner_rel = rel[owner_idx];
  assign owner_req = req[owner_idx];
  assign wd_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(HOLD_LAST));
  assign owner     = 3'(owner_idx);
  assign rd_data   = ram_q;

  // RAM port follows the owner only while the grant is live; zero otherwise.
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (state == ARB_GRANTED) begin
      ram_address = m_addr[int'(owner_idx) * ADDR_W +: ADDR_W];
      ram_data    = m_data[int'(owner_idx) * DATA_W +: DATA_W];
      ram_wren    = m_wren[owner_idx] & gnt[owner_idx];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner_idx <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state     <= ARB_GRANTED;
            owner_idx <= pick_idx;
            gnt       <= NUM_REQ'(1) << pick_idx;
            hold_cnt  <= '0;
            busy      <= 1'b1;
          end
        end
        ARB_GRANTED: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          // An explicit or implicit release masks a coincident watchdog hit.
          if (owner_rel || !owner_req) begin
            state <= ARB_DRAIN;
            gnt   <= '0;
          end else if (wd_hit) begin
            state   <= ARB_DRAIN;
            gnt     <= '0;
            timeout <= 1'b1;
          end
        end
        ARB_DRAIN: begin
          state  <= ARB_IDLE;
          busy   <= 1'b0;
          rr_ptr <= (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
        end
        default: begin
          state <= ARB_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1024x32 RAM (1-cycle read).
module tb_ram_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req;
  logic [N-1:0]      rel;
  logic [N-1:0]      gnt;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_data;
  logic [N-1:0]      m_wren;
  logic [DW-1:0]     rd_data;
  logic [AW-1:0]     ram_address;
  logic [DW-1:0]     ram_data;
  logic              ram_wren;
  logic [DW-1:0]     ram_q;
  logic              busy;
  logic [2:0]        owner;
  logic              timeout;

  logic [DW-1:0]     mem [0:1023];

  int checks = 0;
  int errors = 0;

  ram_arbiter #(
    .NUM_REQ  (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_HOLD (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .rel         (rel),
    .gnt         (gnt),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_wren      (m_wren),
    .rd_data     (rd_data),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .busy        (busy),
    .owner       (owner),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  end

  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_gnt(input string tag, input logic [N-1:0] exp);
    int n;
    n = 0;
    while (gnt == '0 && n < 10) begin
      tick();
      n++;
    end
    check(tag, 64'(gnt), 64'(exp));
  endtask

  initial begin
    int gap;
    int cnt;
    int tos;
    logic [N-1:0] exp_g;

    reset  = 1'b1;
    req    = '0;
    rel    = '0;
    m_addr = '0;
    m_data = '0;
    m_wren = '0;
    repeat (2) tick();

    check("rst_gnt",  64'(gnt), 64'(0));
    check("rst_wren", 64'(ram_wren), 64'(0));
    check("rst_addr", 64'(ram_address), 64'(0));
    check("rst_data", 64'(ram_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_owner", 64'(owner), 64'(0));
    check("rst_tmo",  64'(timeout), 64'(0));
    reset = 1'b0;
    tick();

    // 1: single write then release
    req = 4'b0001;
    m_addr[0*AW +: AW] = 10'd32;
    m_data[0*DW +: DW] = 32'h8000_0000;
    m_wren[0] = 1'b1;
    tick();
    check("t1_gnt",  64'(gnt), 64'(4'b0001));
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_addr", 64'(ram_address), 64'(32));
    check("t1_data", 64'(ram_data), 64'(32'h8000_0000));
    check("t1_wren", 64'(ram_wren), 64'(1));
    rel = 4'b0001;
    tick();
    rel = '0;
    req = '0;
    m_wren = '0;
    check("t1_drain_gnt",  64'(gnt), 64'(0));
    check("t1_drain_wren", 64'(ram_wren), 64'(0));
    check("t1_drain_busy", 64'(busy), 64'(1));
    check("t1_mem32", 64'(mem[32]), 64'(32'h8000_0000));
    tick();
    check("t1_idle_busy", 64'(busy), 64'(0));

    // 2: round robin across four steady requesters
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      gap = 0;
      while (gnt == '0 && gap < 10) begin
        tick();
        gap++;
      end
      exp_g = 4'b0001 << (g % 4);
      check("t2_order", 64'(gnt), 64'(exp_g));
      check("t2_gap", 64'(gap), 64'((g == 0) ? 1 : 2));
      tick();
      tick();
      rel = gnt;
      if (g == 4) req = '0;
      tick();
      rel = '0;
    end
    check("t2_last_drain", 64'(gnt), 64'(0));
    tick();

    // 3: non-owner writes are ignored, address follows owner
    req = 4'b0100;
    m_addr[2*AW +: AW] = 10'd32;
    tick();
    check("t3_gnt",   64'(gnt), 64'(4'b0100));
    check("t3_owner", 64'(owner), 64'(2));
    req = 4'b0110;
    m_addr[1*AW +: AW] = 10'd64;
    m_data[1*DW +: DW] = 32'hDEAD_BEEF;
    m_wren[1] = 1'b1;
    #1;
    check("t3_wren_blocked", 64'(ram_wren), 64'(0));
    check("t3_addr", 64'(ram_address), 64'(32));
    tick();
    check("t3_rd_data", 64'(rd_data), 64'(32'h8000_0000));
    check("t3_gnt_hold", 64'(gnt), 64'(4'b0100));
    m_addr[2*AW +: AW] = 10'd100;
    #1;
    check("t3_addr_follow", 64'(ram_address), 64'(100));
    rel = 4'b0100;
    req = '0;
    m_wren = '0;
    tick();
    rel = '0;
    check("t3_mem64", 64'(mem[64]), 64'(0));
    tick();

    // 4: watchdog revokes engine 0 after 8 cycles, engine 1 next
    req = 4'b0001;
    wait_gnt("t4_gnt0", 4'b0001);
    req = 4'b0011;
    cnt = 0;
    tos = 0;
    while (gnt == 4'b0001 && cnt < 20) begin
      cnt++;
      if (timeout) tos++;
      tick();
    end
    check("t4_hold_cycles", 64'(cnt), 64'(8));
    check("t4_early_tmo", 64'(tos), 64'(0));
    check("t4_tmo_pulse", 64'(timeout), 64'(1));
    check("t4_drain_gnt", 64'(gnt), 64'(0));
    tick();
    check("t4_tmo_clear", 64'(timeout), 64'(0));
    tick();
    check("t4_next_gnt", 64'(gnt), 64'(4'b0010));
    check("t4_owner", 64'(owner), 64'(1));

    // 5: owner 3 drops req without rel, pointer wraps to 0
    rel = 4'b0010;
    req = 4'b1000;
    tick();
    rel = '0;
    wait_gnt("t5_gnt3", 4'b1000);
    check("t5_owner", 64'(owner), 64'(3));
    req = 4'b0101;
    tick();
    check("t5_drain_gnt",  64'(gnt), 64'(0));
    check("t5_drain_busy", 64'(busy), 64'(1));
    check("t5_no_tmo",     64'(timeout), 64'(0));
    tick();
    tick();
    check("t5_wrap_gnt", 64'(gnt), 64'(4'b0001));

    // 6: async reset in the middle of a write
    m_addr[0*AW +: AW] = 10'd200;
    m_data[0*DW +: DW] = 32'h1234_5678;
    m_wren[0] = 1'b1;
    #1;
    check("t6_wren_pre", 64'(ram_wren), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_gnt",  64'(gnt), 64'(0));
    check("t6_async_wren", 64'(ram_wren), 64'(0));
    check("t6_async_busy", 64'(busy), 64'(0));
    check("t6_async_addr", 64'(ram_address), 64'(0));
    tick();
    reset = 1'b0;
    req = 4'b0100;
    m_wren = '0;
    check("t6_owner_rst", 64'(owner), 64'(0));
    tick();
    check("t6_gnt2", 64'(gnt), 64'(4'b0100));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
